// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, working-state layout and sequencer states.
package sha256_pkg;
  localparam int SHA256_ROUNDS = 64;
  localparam logic [31:0] SHA256_IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } sha_state_t;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} seq_state_e;
  function automatic sha_state_t iv_state();
    return '{a: SHA256_IV[0], b: SHA256_IV[1], c: SHA256_IV[2], d: SHA256_IV[3],
             e: SHA256_IV[4], f: SHA256_IV[5], g: SHA256_IV[6], h: SHA256_IV[7]};
  endfunction
endpackage

// File: rtl/sha256_digest_adder.sv
// sha256_digest_adder: eight independent modular word adds of H and the final working state.
module sha256_digest_adder #(
  parameter int WORD_W = 32
) (
  input  logic [8*WORD_W-1:0] h_i,
  input  logic [8*WORD_W-1:0] state_i,
  output logic [8*WORD_W-1:0] sum_o
);
  for (genvar i = 0; i < 8; i++) begin : g_word
    assign sum_o[i*WORD_W +: WORD_W] = h_i[i*WORD_W +: WORD_W] + state_i[i*WORD_W +: WORD_W];
  end
endmodule

// File: rtl/sha256_round_sequencer.sv
// sha256_round_sequencer: steps an external round datapath through one block and folds it into H.
module sha256_round_sequencer
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int WORD_W = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      first_block,
  input  logic                      wk_valid,
  output logic                      busy,
  output logic                      rnd_en,
  output logic [$clog2(ROUNDS)-1:0] rnd_idx,
  output logic [8*WORD_W-1:0]       rnd_state,
  input  logic [8*WORD_W-1:0]       rnd_next_state,
  output logic                      done,
  output logic [8*WORD_W-1:0]       digest
);
  localparam int IW = $clog2(ROUNDS);
  localparam int SW = 8 * WORD_W;
  seq_state_e    state_q, state_d;
  logic [SW-1:0] h_q, h_d, dig_q, dig_d, rs_q, rs_d, sum;
  logic [IW-1:0] idx_q, idx_d;
  logic          last;
  sha256_digest_adder #(.WORD_W(WORD_W)) u_add (
    .h_i    (h_q),
    .state_i(rs_q),
    .sum_o  (sum)
  );
  assign last = idx_q == IW'(ROUNDS - 1);
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    dig_d   = dig_q;
    rs_d    = rs_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        h_d     = first_block ? SW'(iv_state()) : dig_q;
      end
      LOAD: begin
        state_d = ROUND;
        rs_d    = h_q;
        idx_d   = '0;
      end
      // the index saturates on the last round so it never wraps inside a block
      ROUND: if (wk_valid) begin
        rs_d    = rnd_next_state;
        idx_d   = last ? idx_q : idx_q + 1'b1;
        state_d = last ? FINAL : ROUND;
      end
      FINAL: begin
        h_d     = sum;
        dig_d   = sum;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      dig_q   <= '0;
      rs_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      dig_q   <= dig_d;
      rs_q    <= rs_d;
      idx_q   <= idx_d;
    end
  end
  assign busy      = state_q inside {LOAD, ROUND, FINAL};
  assign rnd_en    = (state_q == ROUND) && wk_valid;
  assign done      = state_q == DONE;
  assign rnd_idx   = idx_q;
  assign rnd_state = rs_q;
  assign digest    = dig_q;
endmodule
